// File: rtl/adrv9001_spi_cmd_if.sv
// Command/response, MOSI/MISO byte-stream and SPI enable bundle for adrv9001_spi_cmd.
// The slave modport is the sequencer's view; master is the view of whatever drives it.
interface adrv9001_spi_cmd_if;
  logic [14:0] cmd_addr;
  logic        cmd_rnw;
  logic [7:0]  cmd_wdata;
  logic        cmd_valid;
  logic        cmd_ready;

  logic [7:0]  rsp_rdata;
  logic        rsp_error;
  logic        rsp_valid;
  logic        rsp_ready;

  logic [7:0]  m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;

  logic        spi_enable;

  logic [7:0]  s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tready;

  modport slave (
    input  cmd_addr, cmd_rnw, cmd_wdata, cmd_valid,
    output cmd_ready,
    output rsp_rdata, rsp_error, rsp_valid,
    input  rsp_ready,
    output m_axis_tdata, m_axis_tvalid,
    input  m_axis_tready,
    output spi_enable,
    input  s_axis_tdata, s_axis_tvalid,
    output s_axis_tready
  );

  modport master (
    output cmd_addr, cmd_rnw, cmd_wdata, cmd_valid,
    input  cmd_ready,
    input  rsp_rdata, rsp_error, rsp_valid,
    output rsp_ready,
    input  m_axis_tdata, m_axis_tvalid,
    output m_axis_tready,
    input  spi_enable,
    output s_axis_tdata, s_axis_tvalid,
    input  s_axis_tready
  );
endinterface

// File: rtl/adrv9001_spi_cmd.sv
// ADRV9001 register-access sequencer: builds the 3-byte SPI frame, pushes it to the
// byte-level SPI master, enables the transfer and returns the third MISO byte or a timeout.
module adrv9001_spi_cmd #(
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter logic [7:0]  READ_DUMMY     = 8'h00
) (
  input  logic               clk,
  input  logic               rst,
  adrv9001_spi_cmd_if.slave  bus,
  output logic               busy
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    WAIT_RX = 2'd2,
    RESP    = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [7:0]    frame_b0, frame_b1, frame_b2;
  logic [1:0]    byte_idx;
  logic [1:0]    rx_cnt;
  logic [TW-1:0] to_cnt;
  logic          ready_en;
  logic [7:0]    rdata_q;
  logic          error_q;

  logic          cmd_ready_c;
  logic          m_tvalid_c;
  logic [7:0]    m_tdata_c;
  logic          s_tready_c;
  logic          spi_enable_c;
  logic          rsp_valid_c;
  logic          accept;
  logic          rx_pop;
  logic          rx_last;
  logic          to_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    cmd_ready_c  = 1'b0;
    m_tvalid_c   = 1'b0;
    s_tready_c   = 1'b0;
    spi_enable_c = 1'b0;
    rsp_valid_c  = 1'b0;
    accept       = 1'b0;
    rx_pop       = 1'b0;
    rx_last      = 1'b0;
    to_hit       = 1'b0;

    unique case (byte_idx)
      2'd0:    m_tdata_c = frame_b0;
      2'd1:    m_tdata_c = frame_b1;
      default: m_tdata_c = frame_b2;
    endcase

    unique case (state)
      IDLE: begin
        // Stale MISO bytes win over a new command so every frame starts with an empty FIFO.
        s_tready_c  = ready_en;
        cmd_ready_c = ready_en & ~bus.s_axis_tvalid;
        accept      = bus.cmd_valid & cmd_ready_c;
        if (accept) state_nxt = LOAD;
      end
      LOAD: begin
        m_tvalid_c = 1'b1;
        if (bus.m_axis_tready && byte_idx == 2'd2) state_nxt = WAIT_RX;
      end
      WAIT_RX: begin
        s_tready_c   = 1'b1;
        spi_enable_c = (rx_cnt == 2'd0);
        rx_pop       = bus.s_axis_tvalid;
        rx_last      = rx_pop && (rx_cnt == 2'd2);
        to_hit       = !rx_last && (to_cnt == TO_LAST);
        if (rx_last || to_hit) state_nxt = RESP;
      end
      RESP: begin
        rsp_valid_c = 1'b1;
        if (bus.rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_en <= 1'b0;
      frame_b0 <= '0;
      frame_b1 <= '0;
      frame_b2 <= '0;
      byte_idx <= '0;
      rx_cnt   <= '0;
      to_cnt   <= '0;
      rdata_q  <= '0;
      error_q  <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (accept) begin
        frame_b0 <= {bus.cmd_rnw, bus.cmd_addr[14:8]};
        frame_b1 <= bus.cmd_addr[7:0];
        frame_b2 <= bus.cmd_rnw ? READ_DUMMY : bus.cmd_wdata;
        byte_idx <= '0;
      end
      if (state == LOAD) begin
        // Counters are held clear while loading so they start at zero on WAIT_RX entry.
        rx_cnt <= '0;
        to_cnt <= '0;
        if (bus.m_axis_tready) byte_idx <= byte_idx + 2'd1;
      end
      if (state == WAIT_RX) begin
        to_cnt <= to_cnt + TW'(1);
        if (rx_pop) rx_cnt <= rx_cnt + 2'd1;
        if (rx_last) begin
          rdata_q <= bus.s_axis_tdata;
          error_q <= 1'b0;
        end else if (to_hit) begin
          rdata_q <= '0;
          error_q <= 1'b1;
        end
      end
    end
  end

  assign bus.cmd_ready     = cmd_ready_c;
  assign bus.m_axis_tvalid = m_tvalid_c;
  assign bus.m_axis_tdata  = m_tdata_c;
  assign bus.s_axis_tready = s_tready_c;
  assign bus.spi_enable    = spi_enable_c;
  assign bus.rsp_valid     = rsp_valid_c;
  assign bus.rsp_rdata     = rdata_q;
  assign bus.rsp_error     = error_q;
  assign busy              = (state != IDLE);

endmodule

// File: tb/tb_adrv9001_spi_cmd.sv
// Self-checking bench for adrv9001_spi_cmd: emulates the SPI master's MOSI/MISO FIFOs
// and compares frames and responses against a frame-level reference model.
module tb_adrv9001_spi_cmd;

  logic clk = 1'b0;
  logic rst;
  logic busy;

  adrv9001_spi_cmd_if bus();

  adrv9001_spi_cmd #(
    .TIMEOUT_CYCLES(16),
    .READ_DUMMY    (8'h00)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  logic [7:0] mosi_q[$];
  logic [7:0] miso_q[$];

  int o_accept, o_first_tv, o_b2, o_rsp, o_last_pop, o_en_first;
  int o_stale_pops, o_fresh_pops;
  bit o_en_early, o_en_late, o_unstable, o_stale_bad, o_b2b_bad, o_budget, o_idle_bad;
  logic [7:0] o_rdata;
  logic       o_err;

  // Reference frame: {rnw, addr[14:8]}, addr[7:0], then write data or the read dummy.
  function automatic logic [7:0] exp_byte(input logic [14:0] addr, input logic rnw,
                                          input logic [7:0] wdata, input int i);
    logic [7:0] hi;
    hi = {rnw, addr[14:8]};
    if (i == 0) return hi;
    if (i == 1) return addr[7:0];
    return rnw ? 8'h00 : wdata;
  endfunction

  task automatic drive_miso();
    bus.s_axis_tvalid = (miso_q.size() != 0);
    bus.s_axis_tdata  = (miso_q.size() != 0) ? miso_q[0] : 8'h00;
  endtask

  // Runs one command end to end with an emulated SPI master; records observations only.
  task automatic do_xact(input logic [14:0] addr, input logic rnw, input logic [7:0] wdata,
                         input logic [7:0] r2, input bit respond, input bit toggle,
                         input int hold, input int stale, input bit b2b);
    int cyc;
    int pushed;
    bit accepted, done, cmd_fire, mosi_fire, miso_fire, rsp_fire;
    cyc = 0; pushed = 0; accepted = 0; done = 0;
    o_accept = -1; o_first_tv = -1; o_b2 = -1; o_rsp = -1; o_last_pop = -1; o_en_first = -1;
    o_stale_pops = 0; o_fresh_pops = 0;
    o_en_early = 0; o_en_late = 0; o_unstable = 0; o_stale_bad = 0; o_b2b_bad = 0;
    o_budget = 0; o_idle_bad = 0; o_rdata = 8'hxx; o_err = 1'bx;
    mosi_q.delete();
    miso_q.delete();
    for (int i = 0; i < stale; i++) miso_q.push_back(8'($urandom));
    bus.cmd_addr = addr; bus.cmd_rnw = rnw; bus.cmd_wdata = wdata;
    bus.cmd_valid = 1'b1; bus.rsp_ready = 1'b0;
    while (!done) begin
      if (cyc >= 300) begin o_budget = 1; break; end
      bus.m_axis_tready = toggle ? ((cyc % 2) == 1) : 1'b1;
      drive_miso();
      bus.rsp_ready = (o_rsp >= 0) && (cyc - o_rsp >= hold);
      if (b2b && o_rsp >= 0) bus.cmd_valid = 1'b1;
      #1;
      cmd_fire  = (bus.cmd_valid & bus.cmd_ready) === 1'b1;
      mosi_fire = (bus.m_axis_tvalid & bus.m_axis_tready) === 1'b1;
      miso_fire = (bus.s_axis_tvalid & bus.s_axis_tready) === 1'b1;
      rsp_fire  = (bus.rsp_valid & bus.rsp_ready) === 1'b1;
      if (bus.cmd_ready === 1'b1 && bus.s_axis_tvalid) o_stale_bad = 1;
      if (bus.rsp_valid === 1'b1 && bus.cmd_ready === 1'b1) o_b2b_bad = 1;
      if (bus.m_axis_tvalid === 1'b1 && o_first_tv < 0) o_first_tv = cyc;
      if (bus.spi_enable === 1'b1) begin
        if (mosi_q.size() < 3) o_en_early = 1;
        if (o_fresh_pops > 0) o_en_late = 1;
        if (o_en_first < 0) o_en_first = cyc;
      end
      if (bus.rsp_valid === 1'b1) begin
        if (o_rsp < 0) begin
          o_rsp = cyc; o_rdata = bus.rsp_rdata; o_err = bus.rsp_error;
        end else if (bus.rsp_rdata !== o_rdata || bus.rsp_error !== o_err) begin
          o_unstable = 1;
        end
      end
      if (cmd_fire) o_accept = cyc;
      if (mosi_fire) begin
        mosi_q.push_back(bus.m_axis_tdata);
        if (mosi_q.size() == 3) o_b2 = cyc + 1;
      end
      if (miso_fire) begin
        void'(miso_q.pop_front());
        if (accepted) begin o_fresh_pops++; o_last_pop = cyc; end
        else o_stale_pops++;
      end
      if (respond && o_en_first >= 0 && pushed < 3 && cyc >= o_en_first + 2) begin
        miso_q.push_back(pushed == 2 ? r2 : 8'($urandom));
        pushed++;
      end
      if (cmd_fire) accepted = 1;
      if (rsp_fire) done = 1;
      @(posedge clk); #1;
      cyc++;
      if (cmd_fire || (b2b && rsp_fire)) begin
        bus.cmd_valid = 1'b0;
        bus.cmd_addr = 15'($urandom); bus.cmd_rnw = 1'($urandom); bus.cmd_wdata = 8'($urandom);
      end
    end
    bus.rsp_ready = 1'b0; bus.cmd_valid = 1'b0;
    drive_miso();
    #1;
    if (bus.rsp_valid !== 1'b0 || busy !== 1'b0) o_idle_bad = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.cmd_addr = '0; bus.cmd_rnw = 1'b0; bus.cmd_wdata = '0; bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b0; bus.m_axis_tready = 1'b1;
    bus.s_axis_tvalid = 1'b0; bus.s_axis_tdata = '0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (bus.cmd_ready !== 1'b0) begin n_err++; $display("FAIL reset_cmd_ready: got %b want 0", bus.cmd_ready); end
    n_checks++; if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid: got %b want 0", bus.rsp_valid); end
    n_checks++; if (bus.rsp_error !== 1'b0) begin n_err++; $display("FAIL reset_rsp_error: got %b want 0", bus.rsp_error); end
    n_checks++; if (bus.rsp_rdata !== 8'h00) begin n_err++; $display("FAIL reset_rsp_rdata: got %h want 00", bus.rsp_rdata); end
    n_checks++; if (bus.m_axis_tvalid !== 1'b0) begin n_err++; $display("FAIL reset_m_tvalid: got %b want 0", bus.m_axis_tvalid); end
    n_checks++; if (bus.spi_enable !== 1'b0) begin n_err++; $display("FAIL reset_spi_enable: got %b want 0", bus.spi_enable); end
    n_checks++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    rst = 1'b0;
    #1;
    n_checks++; if (bus.cmd_ready !== 1'b0) begin n_err++; $display("FAIL reset_release_ready: got %b want 0", bus.cmd_ready); end
    @(posedge clk); #1;
    n_checks++; if (bus.cmd_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready_after: got %b want 1", bus.cmd_ready); end
  endtask

  task automatic test_write();
    logic [7:0] want[3];
    logic [7:0] r2;
    want = '{8'h01, 8'h23, 8'hA5};
    r2 = 8'($urandom);
    do_xact(15'h0123, 1'b0, 8'hA5, r2, 1, 0, 0, 0, 0);
    n_checks++; if (o_budget) begin n_err++; $display("FAIL write_budget: got timeout want completion"); end
    n_checks++; if (mosi_q.size() != 3) begin n_err++; $display("FAIL write_count: got %0d want 3", mosi_q.size()); end
    for (int i = 0; i < 3 && i < mosi_q.size(); i++) begin
      n_checks++; if (mosi_q[i] !== want[i]) begin n_err++; $display("FAIL write_b%0d: got %h want %h", i, mosi_q[i], want[i]); end
    end
    n_checks++; if (o_en_early) begin n_err++; $display("FAIL write_en_early: got 1 want 0"); end
    n_checks++; if (o_en_first != o_b2) begin n_err++; $display("FAIL write_en_rise: got cyc %0d want %0d", o_en_first, o_b2); end
    n_checks++; if (o_en_late) begin n_err++; $display("FAIL write_en_after_pop: got 1 want 0"); end
    n_checks++; if (o_first_tv != o_accept + 1) begin n_err++; $display("FAIL write_tv_latency: got %0d want %0d", o_first_tv, o_accept + 1); end
    n_checks++; if (o_rsp != o_last_pop + 1) begin n_err++; $display("FAIL write_rsp_latency: got %0d want %0d", o_rsp, o_last_pop + 1); end
    n_checks++; if (o_err !== 1'b0) begin n_err++; $display("FAIL write_error: got %b want 0", o_err); end
    n_checks++; if (o_rdata !== r2) begin n_err++; $display("FAIL write_rdata: got %h want %h", o_rdata, r2); end
    n_checks++; if (o_idle_bad) begin n_err++; $display("FAIL write_idle_after: got busy want idle"); end
  endtask

  task automatic test_read();
    logic [7:0] want[3];
    want = '{8'hFF, 8'hFE, 8'h00};
    do_xact(15'h7FFE, 1'b1, 8'($urandom), 8'h5C, 1, 0, 0, 0, 0);
    n_checks++; if (mosi_q.size() != 3) begin n_err++; $display("FAIL read_count: got %0d want 3", mosi_q.size()); end
    for (int i = 0; i < 3 && i < mosi_q.size(); i++) begin
      n_checks++; if (mosi_q[i] !== want[i]) begin n_err++; $display("FAIL read_b%0d: got %h want %h", i, mosi_q[i], want[i]); end
    end
    n_checks++; if (o_rdata !== 8'h5C) begin n_err++; $display("FAIL read_rdata: got %h want 5c", o_rdata); end
    n_checks++; if (o_err !== 1'b0) begin n_err++; $display("FAIL read_error: got %b want 0", o_err); end
  endtask

  task automatic test_backpressure();
    logic [14:0] a;
    logic [7:0]  w;
    a = 15'($urandom); w = 8'($urandom);
    do_xact(a, 1'b0, w, 8'($urandom), 1, 1, 0, 0, 0);
    n_checks++; if (mosi_q.size() != 3) begin n_err++; $display("FAIL bp_count: got %0d want 3", mosi_q.size()); end
    for (int i = 0; i < 3 && i < mosi_q.size(); i++) begin
      n_checks++; if (mosi_q[i] !== exp_byte(a, 1'b0, w, i)) begin n_err++; $display("FAIL bp_b%0d: got %h want %h", i, mosi_q[i], exp_byte(a, 1'b0, w, i)); end
    end
    n_checks++; if (o_en_early) begin n_err++; $display("FAIL bp_en_early: got 1 want 0"); end
  endtask

  task automatic test_stale();
    logic [7:0] r2;
    r2 = 8'($urandom);
    do_xact(15'($urandom), 1'b1, 8'($urandom), r2, 1, 0, 0, 2, 0);
    n_checks++; if (o_stale_pops != 2) begin n_err++; $display("FAIL stale_pops: got %0d want 2", o_stale_pops); end
    n_checks++; if (o_accept != 2) begin n_err++; $display("FAIL stale_accept_cyc: got %0d want 2", o_accept); end
    n_checks++; if (o_stale_bad) begin n_err++; $display("FAIL stale_ready_with_tvalid: got 1 want 0"); end
    n_checks++; if (o_fresh_pops != 3) begin n_err++; $display("FAIL stale_fresh_pops: got %0d want 3", o_fresh_pops); end
    n_checks++; if (o_rdata !== r2) begin n_err++; $display("FAIL stale_rdata: got %h want %h", o_rdata, r2); end
  endtask

  task automatic test_timeout();
    do_xact(15'($urandom), 1'b1, 8'($urandom), 8'($urandom), 0, 0, 0, 0, 0);
    n_checks++; if (o_err !== 1'b1) begin n_err++; $display("FAIL timeout_error: got %b want 1", o_err); end
    n_checks++; if (o_rdata !== 8'h00) begin n_err++; $display("FAIL timeout_rdata: got %h want 00", o_rdata); end
    n_checks++; if (o_rsp - o_b2 != 16) begin n_err++; $display("FAIL timeout_cycles: got %0d want 16", o_rsp - o_b2); end
    n_checks++; if (o_idle_bad) begin n_err++; $display("FAIL timeout_idle_after: got busy want idle"); end
  endtask

  task automatic test_hold();
    logic [7:0] r2;
    r2 = 8'($urandom);
    do_xact(15'($urandom), 1'b1, 8'($urandom), r2, 1, 0, 10, 0, 0);
    n_checks++; if (o_unstable) begin n_err++; $display("FAIL hold_stable: got change want stable"); end
    n_checks++; if (o_rdata !== r2) begin n_err++; $display("FAIL hold_rdata: got %h want %h", o_rdata, r2); end
  endtask

  task automatic test_back_to_back();
    do_xact(15'($urandom), 1'b0, 8'($urandom), 8'($urandom), 1, 0, 2, 0, 1);
    n_checks++; if (o_b2b_bad) begin n_err++; $display("FAIL b2b_ready_in_resp: got 1 want 0"); end
    n_checks++; if (o_idle_bad) begin n_err++; $display("FAIL b2b_idle_after: got busy want idle"); end
  endtask

  task automatic test_reset_mid();
    bus.cmd_addr = 15'h2A55; bus.cmd_rnw = 1'b0; bus.cmd_wdata = 8'h11; bus.cmd_valid = 1'b1;
    bus.m_axis_tready = 1'b0; bus.s_axis_tvalid = 1'b0; bus.rsp_ready = 1'b0;
    #1;
    n_checks++; if (bus.cmd_ready !== 1'b1) begin n_err++; $display("FAIL mid_accept: got %b want 1", bus.cmd_ready); end
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    #1;
    n_checks++; if (bus.m_axis_tdata !== 8'h2A) begin n_err++; $display("FAIL mid_b0: got %h want 2a", bus.m_axis_tdata); end
    bus.m_axis_tready = 1'b1;
    @(posedge clk); #1;
    bus.m_axis_tready = 1'b0;
    #1;
    n_checks++; if (bus.m_axis_tdata !== 8'h55) begin n_err++; $display("FAIL mid_b1: got %h want 55", bus.m_axis_tdata); end
    rst = 1'b1;
    #1;
    n_checks++; if (bus.m_axis_tvalid !== 1'b0) begin n_err++; $display("FAIL mid_rst_tvalid: got %b want 0", bus.m_axis_tvalid); end
    n_checks++; if (busy !== 1'b0) begin n_err++; $display("FAIL mid_rst_busy: got %b want 0", busy); end
    n_checks++; if (bus.spi_enable !== 1'b0) begin n_err++; $display("FAIL mid_rst_enable: got %b want 0", bus.spi_enable); end
    n_checks++; if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL mid_rst_rsp_valid: got %b want 0", bus.rsp_valid); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    do_xact(15'h0456, 1'b0, 8'h77, 8'h9E, 1, 0, 0, 0, 0);
    n_checks++; if (mosi_q.size() != 3) begin n_err++; $display("FAIL mid_after_count: got %0d want 3", mosi_q.size()); end
    for (int i = 0; i < 3 && i < mosi_q.size(); i++) begin
      n_checks++; if (mosi_q[i] !== exp_byte(15'h0456, 1'b0, 8'h77, i)) begin n_err++; $display("FAIL mid_after_b%0d: got %h want %h", i, mosi_q[i], exp_byte(15'h0456, 1'b0, 8'h77, i)); end
    end
    n_checks++; if (o_err !== 1'b0 || o_rdata !== 8'h9E) begin n_err++; $display("FAIL mid_after_rsp: got err %b data %h want err 0 data 9e", o_err, o_rdata); end
  endtask

  task automatic test_random();
    logic [14:0] a;
    logic        rnw;
    logic [7:0]  w, r2;
    for (int n = 0; n < 12; n++) begin
      a = 15'($urandom); rnw = 1'($urandom); w = 8'($urandom); r2 = 8'($urandom);
      do_xact(a, rnw, w, r2, 1, 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 2), 0);
      n_checks++; if (mosi_q.size() != 3 || o_budget) begin n_err++; $display("FAIL rand%0d_count: got %0d want 3", n, mosi_q.size()); end
      for (int i = 0; i < 3 && i < mosi_q.size(); i++) begin
        n_checks++; if (mosi_q[i] !== exp_byte(a, rnw, w, i)) begin n_err++; $display("FAIL rand%0d_b%0d: got %h want %h", n, i, mosi_q[i], exp_byte(a, rnw, w, i)); end
      end
      n_checks++; if (o_rdata !== r2 || o_err !== 1'b0) begin n_err++; $display("FAIL rand%0d_rsp: got err %b data %h want err 0 data %h", n, o_err, o_rdata, r2); end
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_backpressure();
    test_stale();
    test_timeout();
    test_hold();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/adrv9001_spi_cmd.md
Name: adrv9001_spi_cmd

Overview:
Register-access sequencer that sits directly upstream of the ADRV9001 byte-level SPI master. It converts one register command (15-bit address, R/W flag, 8-bit write data) into the 3-byte ADRV9001 SPI frame and pushes it into the master's MOSI byte stream. It then enables the transfer, collects the 3 returned MISO bytes and reports the read byte (or a timeout error) on a response handshake.

Parameters:
TIMEOUT_CYCLES, 4096, clk cycles allowed in WAIT_RX before aborting with error; counter width $clog2(TIMEOUT_CYCLES+1)
READ_DUMMY, 8'h00, byte sent in the data slot of a read frame

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  asynchronous active-high reset
cmd_addr  input  15  register address
cmd_rnw  input  1  1 = read, 0 = write
cmd_wdata  input  8  write data (ignored for reads)
cmd_valid  input  1  command valid
cmd_ready  output  1  command accepted when cmd_valid & cmd_ready
rsp_rdata  output  8  third MISO byte of frame (read data); 8'h00 on error
rsp_error  output  1  1 = timeout abort
rsp_valid  output  1  response valid; held until rsp_ready
rsp_ready  input  1  response consumer ready
m_axis_tdata  output  8  MOSI byte to SPI master
m_axis_tvalid  output  1  MOSI byte valid
m_axis_tready  input  1  SPI master MOSI FIFO not full
spi_enable  output  1  transfer enable to SPI master
s_axis_tdata  input  8  MISO byte from SPI master (first-word-fall-through)
s_axis_tvalid  input  1  MISO byte available
s_axis_tready  output  1  pops MISO FIFO when high with tvalid
busy  output  1  high in any state except IDLE

Behaviour:
- Reset (async assert, sync release): state=IDLE, cmd_ready=0 for the first cycle after release, rsp_valid=0, rsp_error=0, rsp_rdata=0, m_axis_tvalid=0, spi_enable=0, counters=0.
- States: IDLE, LOAD, WAIT_RX, RESP.
- Frame byte order: B0={cmd_rnw,cmd_addr[14:8]}, B1=cmd_addr[7:0], B2=cmd_wdata (write) or READ_DUMMY (read).
- The frame is latched into internal registers on acceptance; inputs are don't-care afterwards.
- IDLE:
  - cmd_ready=1, except when s_axis_tvalid=1.
  - s_axis_tready=1: stale MISO bytes are drained and discarded. A stale byte blocks command acceptance in that cycle (drain priority).
  - On cmd accept -> LOAD with byte index 0.
- LOAD:
  - m_axis_tvalid=1 with byte[idx]; idx advances on m_axis_tready.
  - Backpressure stalls without data loss.
  - After B2 is accepted -> WAIT_RX. spi_enable stays 0 throughout LOAD, so CS cannot drop on a partial frame.
- WAIT_RX:
  - spi_enable=1 until the first MISO byte is popped, then 0.
  - s_axis_tready=1; rx counter counts popped bytes 0..3. The byte popped as count 2 (third) is stored into rsp_rdata.
  - After the third pop -> RESP with rsp_error=0.
  - The timeout counter increments every WAIT_RX cycle and clears on entry. When it reaches TIMEOUT_CYCLES -> RESP with rsp_error=1 and rsp_rdata=0. Partial rx bytes remaining in the master FIFO are drained later by IDLE.
- RESP:
  - rsp_valid=1, outputs stable until rsp_ready; then -> IDLE in the next cycle.
  - Writes also produce a response; rsp_rdata is the third MISO byte (don't-care to software).
- Latency: cmd accept to first m_axis_tvalid = 1 cycle. Last MISO pop to rsp_valid = 1 cycle.
- Simultaneous: rsp_ready and a new cmd_valid in the same cycle is not a back-to-back accept; cmd_ready rises only in IDLE.
- Reset mid-operation: immediately returns to IDLE. Bytes already pushed to the master are not recalled.
- No overlapping commands; one outstanding frame at a time.

Test Plan:
- Write addr 15'h0123, wdata 8'hA5, m_axis_tready=1 -> MOSI bytes 8'h01, 8'h23, 8'hA5 in order; spi_enable rises only after B2; rsp_valid, rsp_error=0.
- Read addr 15'h7FFE, slave returns 8'hxx, 8'hxx, 8'h5C -> MOSI 8'hFF, 8'hFE, 8'h00; rsp_rdata=8'h5C, rsp_error=0.
- m_axis_tready toggled 0/1 every other cycle during LOAD -> exactly 3 MOSI bytes, no duplicates or skips, spi_enable=0 until B2 accepted.
- Two stale MISO bytes present in IDLE while cmd_valid=1 -> both popped and discarded first; command accepted the cycle after the FIFO is empty; response uses only fresh bytes.
- TIMEOUT_CYCLES=16, slave returns no MISO bytes -> rsp_valid with rsp_error=1 and rsp_rdata=8'h00 exactly 16 cycles after entering WAIT_RX.
- Assert rst during LOAD after B0 -> all outputs at reset values within the same cycle; a subsequent write completes normally. Hold rsp_ready=0 for 10 cycles -> rsp_valid and rsp_rdata stay stable.
